// File: rtl/the_clock_pkg.sv
// Shared widths and types for the 24-hour seconds-of-day counter.
// Pure declarations: no latency, no flow control.
package the_clock_pkg;
    localparam int unsigned TIME_W          = 24;
    localparam int unsigned SECONDS_PER_DAY = 86400;

    typedef logic [TIME_W-1:0] tod_t;
endpackage

// File: rtl/the_tick_gen.sv
// Prescaler: divides clk down to a one-cycle sec_tick every TICKS_PER_SEC cycles.
// Latency: sec_tick is high during the last count (TICKS_PER_SEC-1) after a clear/reset.
// Backpressure: none; free-running, clear restarts the count at 0.
module the_tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic sec_tick
);
    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Decoded from the count so the increment lands exactly TICKS_PER_SEC edges after a clear.
    assign sec_tick = (cnt == CNT_LAST);
endmodule

// File: rtl/the_clock_24h.sv
// Seconds-of-day counter (0..SECONDS_PER_DAY-1) with change-detected load from time_in.
// Latency: a valid time_in change shows on time_out 1 cycle later; ticks advance it once per second.
// Backpressure: none; out-of-range loads are dropped, a load beats a coincident tick.
module the_clock_24h
    import the_clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC   = 100_000_000,
    parameter int unsigned SECONDS_PER_DAY = the_clock_pkg::SECONDS_PER_DAY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TIME_W-1:0] time_in,
    output logic [TIME_W-1:0] time_out
);
    localparam tod_t DAY_LAST = tod_t'(SECONDS_PER_DAY - 1);

    tod_t time_in_q;
    logic load_req;
    logic load_ok;
    logic sec_tick;

    // Only a change is a request, so a held value is applied once and then lets the clock run.
    assign load_req = (time_in != time_in_q);
    assign load_ok  = load_req && (time_in <= DAY_LAST);

    the_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_ok),
        .sec_tick (sec_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_in_q <= '0;
            time_out  <= '0;
        end else begin
            time_in_q <= time_in;
            if (load_ok) begin
                time_out <= time_in;
            end else if (sec_tick) begin
                time_out <= (time_out >= DAY_LAST) ? '0 : time_out + tod_t'(1);
            end
        end
    end
endmodule

// File: tb/tb_the_clock_24h.sv
// Directed bench for the_clock_24h with a 4-cycle second: reset, load sweep, wrap,
// out-of-range loads, load/tick collision and asynchronous reset.
module tb_the_clock_24h;
    import the_clock_pkg::*;

    logic clk;
    logic reset;
    tod_t time_in;
    tod_t time_out;

    int vectors     = 0;
    int miscompares = 0;

    the_clock_24h #(
        .TICKS_PER_SEC   (4),
        .SECONDS_PER_DAY (86400)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .time_in  (time_in),
        .time_out (time_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input tod_t obs, input tod_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tod_t v;

        // Reset with time_in = 0, then 3 quiet edges and the first increment on the 4th.
        reset   = 1'b1;
        time_in = '0;
        step(2);
        check("reset_hold", time_out, 24'd0);
        reset = 1'b0;
        step(3);
        check("no_tick_3_cycles", time_out, 24'd0);
        step(1);
        check("first_tick", time_out, 24'd1);

        // Load latency: no combinational path, value appears after one edge.
        time_in = 24'd4242;
        #1;
        check("no_comb_path", time_out, 24'd1);
        step(1);
        check("load_latency", time_out, 24'd4242);

        // Strided load sweep plus both ends of the range, each held 2 cycles.
        for (int k = 0; k <= 100; k++) begin
            v       = tod_t'(k * 863 + 17);
            time_in = v;
            step(1);
            check("sweep_load", time_out, v);
            step(1);
            check("sweep_hold", time_out, v);
        end
        time_in = 24'd86399;
        step(1);
        check("load_max", time_out, 24'd86399);
        step(1);
        time_in = 24'd0;
        step(1);
        check("load_zero", time_out, 24'd0);
        step(1);

        // Tick and day wrap.
        time_in = 24'd86398;
        step(1);
        check("wrap_load", time_out, 24'd86398);
        step(3);
        check("wrap_pre_tick", time_out, 24'd86398);
        step(1);
        check("wrap_86399", time_out, 24'd86399);
        step(3);
        check("wrap_hold", time_out, 24'd86399);
        step(1);
        check("wrap_to_zero", time_out, 24'd0);
        step(4);
        check("after_wrap", time_out, 24'd1);

        // Out-of-range requests are ignored and do not disturb the prescaler.
        time_in = 24'd100;
        step(1);
        check("oor_load_100", time_out, 24'd100);
        time_in = 24'd86400;
        step(1);
        check("oor_86400_ignored", time_out, 24'd100);
        step(2);
        check("oor_pre_tick", time_out, 24'd100);
        step(1);
        check("oor_tick_101", time_out, 24'd101);
        step(4);
        check("oor_tick_102", time_out, 24'd102);
        time_in = 24'hFFFFFF;
        step(1);
        check("oor_ffffff_ignored", time_out, 24'd102);
        step(3);
        check("oor_tick_103", time_out, 24'd103);

        // Load on the tick edge wins; next increment a full second later.
        step(3);
        check("collide_pre", time_out, 24'd103);
        time_in = 24'd500;
        step(1);
        check("collide_load_wins", time_out, 24'd500);
        step(3);
        check("collide_hold", time_out, 24'd500);
        step(1);
        check("collide_next_tick", time_out, 24'd501);

        // Asynchronous reset between edges, then release with time_in still nonzero.
        time_in = 24'd1234;
        step(1);
        check("pre_reset_value", time_out, 24'd1234);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", time_out, 24'd0);
        step(2);
        check("reset_held", time_out, 24'd0);
        reset = 1'b0;
        step(1);
        check("release_load", time_out, 24'd1234);
        step(3);
        check("release_no_tick", time_out, 24'd1234);
        step(1);
        check("release_first_tick", time_out, 24'd1235);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
